// File: rtl/feature_mem_ctrl.sv
// feature_mem_ctrl: loads a G x L tile of bus beats into the feature memory in
// line-major order. It then holds the tile for the compute stage and drains it
// back out in the same order.
//
// Handshake: a bus beat is transferred in the cycle where in_valid && in_ready
// are both high. in_ready is only high in LOAD, and never while abort or rst
// is asserted. in_data must be stable while in_valid is high. feat_valid is
// held in FULL until feat_ack is seen; feat_ack has no effect in other states.
module feature_mem_ctrl #(
    parameter int Tn             = 4,
    parameter int KERNEL_SIZE    = 5,
    parameter int DATA_BUS_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [8:0]                cfg_groups,
    input  logic [3:0]                cfg_lines,
    input  logic                      in_valid,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [8:0]                wr_mem_group,
    output logic [3:0]                wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic                      feat_valid,
    input  logic                      feat_ack,
    output logic                      rd_en,
    output logic [8:0]                rd_mem_group,
    output logic [3:0]                rd_mem_line,
    output logic                      busy,
    output logic                      done,
    input  logic                      abort,
    output logic [1:0]                state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0] state_q, state_d;
    logic [8:0] grp_q, grp_d;
    logic [3:0] line_q, line_d;
    logic [8:0] cfg_g_q, cfg_g_d;
    logic [3:0] cfg_l_q, cfg_l_d;
    logic       done_q, done_d;

    logic [8:0] clamp_g;
    logic [3:0] clamp_l;
    logic       beat_acc;
    logic       rd_fire;
    logic       line_end;
    logic       at_last;
    logic [8:0] grp_inc;
    logic [3:0] line_inc;

    // Clamp the requested tile shape into 1..Tn groups and 1..KERNEL_SIZE lines
    always_comb begin
        clamp_g = cfg_groups;
        if (cfg_groups == 9'd0) begin
            clamp_g = 9'd1;
        end else if (cfg_groups > 9'(Tn)) begin
            clamp_g = 9'(Tn);
        end
        clamp_l = cfg_lines;
        if (cfg_lines == 4'd0) begin
            clamp_l = 4'd1;
        end else if (cfg_lines > 4'(KERNEL_SIZE)) begin
            clamp_l = 4'(KERNEL_SIZE);
        end
    end

    // Transfer qualifiers; abort and rst suppress any memory traffic this cycle
    always_comb begin
        in_ready = (state_q == S_LOAD) && !abort && !rst;
        beat_acc = in_ready && in_valid;
        rd_fire  = (state_q == S_DRAIN) && !abort && !rst;
    end

    // Line-major successor of the current (group, line) position
    always_comb begin
        line_end = (line_q == (cfg_l_q - 4'd1));
        at_last  = line_end && (grp_q == (cfg_g_q - 9'd1));
        if (line_end) begin
            line_inc = 4'd0;
            grp_inc  = grp_q + 9'd1;
        end else begin
            line_inc = line_q + 4'd1;
            grp_inc  = grp_q;
        end
    end

    // Next-state logic: abort wins over every other request
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        line_d  = line_q;
        cfg_g_d = cfg_g_q;
        cfg_l_d = cfg_l_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            grp_d   = 9'd0;
            line_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        cfg_g_d = clamp_g;
                        cfg_l_d = clamp_l;
                        grp_d   = 9'd0;
                        line_d  = 4'd0;
                    end
                end
                S_LOAD: begin
                    // A stalled bus simply holds the position; there is no timeout
                    if (beat_acc) begin
                        if (at_last) begin
                            state_d = S_FULL;
                            grp_d   = 9'd0;
                            line_d  = 4'd0;
                        end else begin
                            grp_d  = grp_inc;
                            line_d = line_inc;
                        end
                    end
                end
                S_FULL: begin
                    if (feat_ack) begin
                        state_d = S_DRAIN;
                        grp_d   = 9'd0;
                        line_d  = 4'd0;
                    end
                end
                S_DRAIN: begin
                    // One read per cycle; the last address ends the job
                    if (at_last) begin
                        state_d = S_IDLE;
                        grp_d   = 9'd0;
                        line_d  = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        grp_d  = grp_inc;
                        line_d = line_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    grp_d   = 9'd0;
                    line_d  = 4'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset that outranks abort and start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grp_q   <= 9'd0;
            line_q  <= 4'd0;
            cfg_g_q <= 9'd0;
            cfg_l_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            line_q  <= line_d;
            cfg_g_q <= cfg_g_d;
            cfg_l_q <= cfg_l_d;
            done_q  <= done_d;
        end
    end

    // Memory command outputs; addresses and data are zero when not enabled
    always_comb begin
        wr_en        = beat_acc;
        wr_mem_group = beat_acc ? grp_q : 9'd0;
        wr_mem_line  = beat_acc ? line_q : 4'd0;
        wr_data      = beat_acc ? in_data : '0;
        rd_en        = rd_fire;
        rd_mem_group = rd_fire ? grp_q : 9'd0;
        rd_mem_line  = rd_fire ? line_q : 4'd0;
        feat_valid   = (state_q == S_FULL);
        busy         = (state_q != S_IDLE);
        done         = done_q;
        state_dbg    = state_q;
    end

endmodule

// File: doc/feature_mem_ctrl.md
FEATURE_MEM_CTRL -- requirements
Module: feature_mem_ctrl

Interface
REQ-001 Parameters SHALL be: Tn, default 4, number of memory groups; KERNEL_SIZE, default 5, lines per group; DATA_BUS_WIDTH, default 64, input beat width.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a load/drain job.
REQ-005 cfg_groups  input  9  active groups for the job, sampled at accepted start.
REQ-006 cfg_lines  input  4  active lines per group, sampled at accepted start.
REQ-007 in_valid  input  1  bus beat present on in_data.
REQ-008 in_data  input  DATA_BUS_WIDTH  bus beat.
REQ-009 in_ready  output  1  controller accepts beat this cycle.
REQ-010 wr_en, wr_mem_group[8:0], wr_mem_line[3:0], wr_data[DATA_BUS_WIDTH-1:0]  output  write command to feature memory.
REQ-011 feat_valid  output  1  loaded tile available to compute.
REQ-012 feat_ack  input  1  compute accepts tile; starts drain.
REQ-013 rd_en, rd_mem_group[8:0], rd_mem_line[3:0]  output  read command to feature memory.
REQ-014 busy  output  1  state not IDLE; done  output  1  one-cycle pulse at job end.
REQ-015 abort  input  1  cancels job from any state.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, FULL, DRAIN; busy = (state != IDLE).
REQ-017 IDLE: start=1 -> LOAD, latch cfg, clear counters; start while busy SHALL be ignored.
REQ-018 cfg_groups 0 SHALL clamp to 1, >Tn to Tn; cfg_lines 0 SHALL clamp to 1, >KERNEL_SIZE to KERNEL_SIZE.
REQ-019 LOAD: in_ready=1; beat accepted when in_valid && in_ready; same cycle wr_en=1, wr_data=in_data, wr_mem_group/wr_mem_line = current counters (combinational, zero latency).
REQ-020 Write order SHALL be line-major: line 0..L-1 within group, then group+1; line wraps to 0 on group increment.
REQ-021 Acceptance of beat (G-1, L-1) SHALL move to FULL next cycle; exactly G*L writes per job.
REQ-022 in_valid low in LOAD SHALL stall counters, wr_en=0, no timeout.
REQ-023 FULL: feat_valid=1, in_ready=0; feat_ack=1 -> DRAIN next cycle, counters cleared; feat_valid SHALL drop in DRAIN.
REQ-024 DRAIN: rd_en=1 every cycle, rd_mem_group/rd_mem_line sweep the same line-major order, one address per cycle, G*L cycles.
REQ-025 Cycle with rd address (G-1, L-1) SHALL be last DRAIN cycle; next cycle state=IDLE, done=1 for one cycle.
REQ-026 feat_ack outside FULL SHALL be ignored; in_valid outside LOAD SHALL not be accepted.
REQ-027 abort=1 SHALL force IDLE next cycle, no done pulse, no write/read in the abort cycle; abort has priority over start, beats and feat_ack.
REQ-028 wr_en and rd_en SHALL never be high in the same cycle.
REQ-029 When wr_en/rd_en low, address outputs SHALL be 0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear counters and latched cfg; outputs in_ready, wr_en, rd_en, feat_valid, busy, done = 0, all addresses 0, wr_data 0.
REQ-031 rst mid-LOAD or mid-DRAIN SHALL drop the job with no done; rst has priority over abort and start.

Verification
REQ-032 start, cfg_groups=2, cfg_lines=3, continuous in_valid -> 6 writes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); feat_valid 1 cycle after 6th beat.
REQ-033 same job, feat_ack in FULL -> 6 consecutive rd_en cycles same order, then done=1 one cycle, busy=0.
REQ-034 cfg_groups=0, cfg_lines=15 with Tn=4, KERNEL_SIZE=5 -> clamp to 1x5: exactly 5 writes, lines 0..4 group 0.
REQ-035 in_valid toggling 1,0,0,1 in LOAD -> counters advance only on valid cycles; no wr_en on idle cycles; second start during LOAD ignored.
REQ-036 abort on 3rd beat of 2x3 load -> no write that cycle, IDLE next, done stays 0; new start then completes normally.
REQ-037 rst asserted mid-DRAIN -> all outputs 0 next cycle, no done, feat_ack after reset ignored.
